beam_thresh_sequencer: RTL

- Owns the per-beam trigger thresholds for the beamform trigger array.
- Holds a shadow RAM of NBEAMS x 2 thresholds, 18 bits each, written from the register side.
- On command, streams the RAM into the beamformer threshold cascade, one beam per cycle, then issues a single update strobe so all beams switch thresholds together.
- Sits between the register/control interface and the beamform trigger's thresh_i/thresh_wr_i/thresh_update_i inputs.

---
 rtl/pueo_thresh_pkg.sv | 19 +
 rtl/thresh_shadow_ram.sv | 30 +++
 rtl/beam_thresh_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pueo_thresh_pkg.sv
// Shared constants and state encoding for the beam threshold sequencer.
// NBEAMS is intentionally absent: the instantiating top owns the beam count.
package pueo_thresh_pkg;

    localparam int TBITS      = 18;
    localparam int GAP_CYCLES = 2;

    localparam logic [TBITS-1:0] DEFAULT_THRESH = 18'd4000;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_READ   = 3'd2,
        ST_STREAM = 3'd3,
        ST_GAP    = 3'd4,
        ST_UPDATE = 3'd5
    } thresh_state_t;

endpackage

// File: rtl/thresh_shadow_ram.sv
// Dual-bank (A/B) shadow threshold RAM: one write port with per-bank enables,
// one shared read port, read-first with a single cycle of read latency.
module thresh_shadow_ram #(
    parameter int DEPTH = 48,
    parameter int TBITS = 18,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic [1:0]         i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [TBITS-1:0]   i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [2*TBITS-1:0] o_rdata
);

    logic [TBITS-1:0] r_memA [DEPTH];
    logic [TBITS-1:0] r_memB [DEPTH];

    // Same-address write and read in one cycle returns the old contents.
    always_ff @(posedge clk_i) begin
        if (i_we[0]) begin
            r_memA[i_waddr] <= i_wdata;
        end
        if (i_we[1]) begin
            r_memB[i_waddr] <= i_wdata;
        end
        o_rdata <= {r_memB[i_raddr], r_memA[i_raddr]};
    end

endmodule

// File: rtl/beam_thresh_sequencer.sv
// Owns the per-beam A/B trigger thresholds and streams them into the
// beamformer cascade on command, finishing with one common update strobe.
module beam_thresh_sequencer #(
    parameter int                NBEAMS         = 48,
    parameter int                TBITS          = pueo_thresh_pkg::TBITS,
    parameter int                GAP_CYCLES     = pueo_thresh_pkg::GAP_CYCLES,
    parameter logic [TBITS-1:0]  DEFAULT_THRESH = pueo_thresh_pkg::DEFAULT_THRESH,
    parameter int                AW             = $clog2(NBEAMS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               thr_wr_i,
    input  logic [AW-1:0]      thr_addr_i,
    input  logic               thr_sel_i,
    input  logic [TBITS-1:0]   thr_dat_i,
    output logic               thr_ready_o,
    input  logic               load_i,
    input  logic [1:0]         load_mask_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               addr_err_o,
    output logic [2*TBITS-1:0] thresh_o,
    output logic [1:0]         thresh_wr_o,
    output logic [1:0]         thresh_update_o
);

    import pueo_thresh_pkg::*;

    localparam logic [AW:0]   LP_NBEAMS   = (AW+1)'(NBEAMS);
    localparam logic [AW-1:0] LP_LAST_IDX = AW'(NBEAMS - 1);
    localparam logic [AW-1:0] LP_GAP_LAST = AW'(GAP_CYCLES - 1);

    thresh_state_t r_state;
    thresh_state_t w_nextState;

    logic [AW-1:0]      r_idx;
    logic [AW-1:0]      w_nextIdx;
    logic [1:0]         r_mask;
    logic [1:0]         r_pendMask;
    logic               r_pending;
    logic               r_addrErr;

    logic               w_loadReq;
    logic               w_busy;
    logic               w_pendNow;
    logic [1:0]         w_pendMaskNow;
    logic               w_startLoad;
    logic               w_regWr;
    logic               w_addrOk;

    logic [1:0]         w_ramWe;
    logic [AW-1:0]      w_ramWaddr;
    logic [TBITS-1:0]   w_ramWdata;
    logic [AW-1:0]      w_ramRaddr;
    logic [2*TBITS-1:0] w_ramRdata;

    assign w_loadReq     = load_i && (load_mask_i != 2'b00);
    assign w_busy        = (r_state != ST_IDLE);
    assign w_pendMaskNow = r_pendMask | (w_loadReq ? load_mask_i : 2'b00);
    assign w_pendNow     = r_pending | (w_loadReq && w_busy);
    assign w_startLoad   = (w_nextState == ST_READ);
    assign w_regWr       = thr_wr_i && (r_state != ST_INIT);
    assign w_addrOk      = ({1'b0, thr_addr_i} < LP_NBEAMS);

    thresh_shadow_ram #(
        .DEPTH (NBEAMS),
        .TBITS (TBITS),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .i_we    (w_ramWe),
        .i_waddr (w_ramWaddr),
        .i_wdata (w_ramWdata),
        .i_raddr (w_ramRaddr),
        .o_rdata (w_ramRdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // r_idx is shared: INIT fill address, STREAM beam index, GAP counter.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        case (r_state)
            ST_INIT: begin
                w_nextIdx = r_idx + AW'(1);
                if (r_idx == LP_LAST_IDX) begin
                    w_nextIdx   = '0;
                    w_nextState = w_pendNow ? ST_READ : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_loadReq) begin
                    w_nextState = ST_READ;
                end
            end
            ST_READ: begin
                w_nextState = ST_STREAM;
                w_nextIdx   = LP_LAST_IDX;
            end
            ST_STREAM: begin
                if (r_idx == '0) begin
                    w_nextState = ST_GAP;
                end else begin
                    w_nextIdx = r_idx - AW'(1);
                end
            end
            ST_GAP: begin
                w_nextIdx = r_idx + AW'(1);
                if (r_idx == LP_GAP_LAST) begin
                    w_nextIdx   = '0;
                    w_nextState = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_nextState = w_pendNow ? ST_READ : ST_IDLE;
            end
            default: begin
                w_nextState = ST_INIT;
                w_nextIdx   = '0;
            end
        endcase
    end

    // Loads requested while busy coalesce into one pending load whose mask
    // is the OR of every request seen since the previous load started.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx      <= '0;
            r_mask     <= '0;
            r_pending  <= 1'b0;
            r_pendMask <= '0;
            r_addrErr  <= 1'b0;
        end else begin
            r_idx <= w_nextIdx;
            if (w_startLoad) begin
                r_mask     <= w_pendMaskNow;
                r_pending  <= 1'b0;
                r_pendMask <= '0;
            end else if (w_loadReq && w_busy) begin
                r_pending  <= 1'b1;
                r_pendMask <= w_pendMaskNow;
            end
            if (w_regWr && !w_addrOk) begin
                r_addrErr <= 1'b1;
            end
        end
    end

    always_comb begin
        thr_ready_o     = (r_state != ST_INIT);
        busy_o          = w_busy;
        done_o          = (r_state == ST_UPDATE);
        addr_err_o      = r_addrErr;
        thresh_o        = '0;
        thresh_wr_o     = 2'b00;
        thresh_update_o = 2'b00;
        w_ramWe         = 2'b00;
        w_ramWaddr      = r_idx;
        w_ramWdata      = DEFAULT_THRESH;
        w_ramRaddr      = '0;

        if (r_state == ST_INIT) begin
            w_ramWe = 2'b11;
        end else if (w_regWr && w_addrOk) begin
            w_ramWe    = thr_sel_i ? 2'b10 : 2'b01;
            w_ramWaddr = thr_addr_i;
            w_ramWdata = thr_dat_i;
        end

        // Reads run one beam ahead so the stream has no bubbles.
        if (r_state == ST_READ) begin
            w_ramRaddr = LP_LAST_IDX;
        end else if (r_state == ST_STREAM && r_idx != '0) begin
            w_ramRaddr = r_idx - AW'(1);
        end

        if (r_state == ST_STREAM) begin
            thresh_wr_o = r_mask;
            thresh_o    = {r_mask[1] ? w_ramRdata[2*TBITS-1:TBITS] : {TBITS{1'b0}},
                           r_mask[0] ? w_ramRdata[TBITS-1:0]       : {TBITS{1'b0}}};
        end

        if (r_state == ST_UPDATE) begin
            thresh_update_o = r_mask;
        end
    end

endmodule
